traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Parametrised two-road intersection controller that extends the single red/green countdown with separate north-south (NS) and east-west (EW) greens, yellow and all-red clearance phases, a pedestrian request that shortens the active green, and a flashing-yellow maintenance mode. It runs on the light-count tick clock and drives the lamp outputs and the remaining-time display counter directly.

## Interface
- CNT_W, 4: width of the phase counter and display value.
- T_GREEN_NS, 9: NS green duration in ticks.
- T_GREEN_EW, 9: EW green duration in ticks.
- T_YELLOW, 3: yellow duration in ticks, both roads.
- T_ALLRED, 1: all-red clearance duration in ticks.
- PED_MIN, 3: remaining green after a pedestrian shortening.
- Legal values: every duration is in 1..2^CNT_W-1, and PED_MIN < min(T_GREEN_NS, T_GREEN_EW).

- clk_light_cnt  in  1  light-count tick clock; one rising edge is one tick.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  tick enable; when low, the state, counter and blink hold.
- ped_req  in  1  pedestrian request pulse, sampled every edge.
- flash_req  in  1  level; requests flashing-yellow mode.
- ns_light  out  3  one-hot {red, yellow, green}; 000 means off.
- ew_light  out  3  one-hot {red, yellow, green}; 000 means off.
- phase_cnt  out  CNT_W  ticks remaining in the current phase.
- ped_pending  out  1  a pedestrian request is latched and not yet served.
- state  out  3  current phase encoding, for debug and display.

## Operation
- Phases cycle in this order: NS_GREEN -> NS_YELLOW -> ALLRED_A -> EW_GREEN -> EW_YELLOW -> ALLRED_B -> NS_GREEN. FLASH sits outside the cycle.
- Lamps per phase:
  - NS_GREEN: NS green, EW red.
  - NS_YELLOW: NS yellow, EW red.
  - EW_GREEN: NS red, EW green.
  - EW_YELLOW: NS red, EW yellow.
  - ALLRED_x: both roads red.
  - FLASH: both roads yellow when blink=1, both off (000) when blink=0.
- On entry to a phase, phase_cnt loads that phase's duration D. Each enabled tick decrements it. On an enabled tick with phase_cnt==1, the block moves to the next phase and loads the new phase's D. A phase therefore lasts exactly D enabled ticks, and the display shows D..1, never 0.
- Priority on an enabled tick is flash > phase end > pedestrian shortening. Only one action is taken per tick.
- Flash entry: flash_req=1 in any non-FLASH phase sends the block to FLASH, with phase_cnt=0, blink=1 and ped_pending cleared.
- Flash behaviour: while in FLASH with flash_req=1, each enabled tick toggles blink.
- Flash exit: flash_req=0 while in FLASH sends the block to ALLRED_B with phase_cnt=T_ALLRED, then normal cycling resumes at NS_GREEN.
- Pedestrian latch: ped_req=1 at any edge sets ped_pending, regardless of en or phase, except in FLASH, where it is ignored.
- Pedestrian shortening: on an enabled tick in NS_GREEN or EW_GREEN with ped_pending=1:
  - if phase_cnt > PED_MIN: phase_cnt loads PED_MIN and ped_pending clears;
  - otherwise the normal decrement applies and ped_pending stays set until yellow is entered.
- Entering NS_YELLOW or EW_YELLOW clears ped_pending.
- If a set (ped_req=1) and a clear occur on the same edge, the set wins, so the new request stays pending.
- Counter arithmetic is unsigned, CNT_W bits, and the counter never wraps: phase_cnt==0 occurs only in FLASH, and no decrement is applied there.

## Timing
- Reset values: state=NS_GREEN, phase_cnt=T_GREEN_NS, ns_light=001, ew_light=100, ped_pending=0, blink=0.
- Reset mid-phase (including FLASH) returns the block immediately to these values; no partial-phase state survives.
- All outputs are registered or decoded from registers only; there is no combinational path from any input to any output.
- Response latencies:
  - Phase change appears at the output on the tick where phase_cnt==1 is seen.
  - flash_req takes effect on the first enabled tick where it is sampled high, i.e. one-tick latency.
  - ped_pending rises on the edge after ped_req.
- en=0 for any number of ticks freezes all timing. On re-enable the phase resumes with the held phase_cnt.

## Structure
- Shared package traffic_pkg holds:
  - the state encoding: NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5, FLASH=6;
  - the lamp constants: RED=100, YEL=010, GRN=001, OFF=000.
- One sub-module, phase_timer: a CNT_W down-counter with load, load value, enable and a last (cnt==1) flag. The controller FSM and lamp decode stay in the top module.

## Test plan
- Reset release, en=1, default parameters: NS green for 9 ticks (phase_cnt 9..1), then NS yellow 3..1, ALLRED_A 1, EW green 9..1, EW yellow, ALLRED_B, back to NS green; one full cycle is 26 ticks.
- ped_req pulse during NS_GREEN at phase_cnt=7: next enabled tick gives phase_cnt=3 and ped_pending=0; NS yellow follows 3 ticks later.
- ped_req pulse at phase_cnt=2 in EW_GREEN: no shortening; ped_pending stays 1 until EW_YELLOW is entered, then reads 0.
- flash_req raised during EW_YELLOW: next tick gives state=FLASH with both lights 010, the tick after both 000, alternating. When flash_req drops: ALLRED_B for 1 tick, then NS_GREEN with phase_cnt=9.
- en held low for 5 ticks at NS_GREEN phase_cnt=4: outputs are frozen; after re-enable the count continues 3, 2, 1.
- rst_n asserted asynchronously mid-FLASH and mid-EW_GREEN: outputs immediately return to the reset values (NS_GREEN, phase_cnt=T_GREEN_NS, ns_light=001, ew_light=100, ped_pending=0); with CNT_W=5, T_GREEN_NS=20, the count runs 20..1 with no wrap.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller: phase encoding,
// lamp patterns and the phase-to-lamp decode helpers.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    FLASH     = 3'd6
  } state_e;

  // One-hot lamp patterns {red, yellow, green}
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  // Successor in the normal cycle; FLASH never reaches here
  function automatic state_e next_phase(input state_e s);
    state_e n;
    case (s)
      NS_GREEN:  n = NS_YELLOW;
      NS_YELLOW: n = ALLRED_A;
      ALLRED_A:  n = EW_GREEN;
      EW_GREEN:  n = EW_YELLOW;
      EW_YELLOW: n = ALLRED_B;
      default:   n = NS_GREEN;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] ns_lamp(input state_e s, input logic blink);
    logic [2:0] l;
    case (s)
      NS_GREEN:  l = GRN;
      NS_YELLOW: l = YEL;
      FLASH:     l = blink ? YEL : OFF;
      default:   l = RED;
    endcase
    return l;
  endfunction

  function automatic logic [2:0] ew_lamp(input state_e s, input logic blink);
    logic [2:0] l;
    case (s)
      EW_GREEN:  l = GRN;
      EW_YELLOW: l = YEL;
      FLASH:     l = blink ? YEL : OFF;
      default:   l = RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter holding the ticks remaining in the current phase.
// Load wins over decrement; the count never decrements below zero.
module phase_timer #(
  parameter int               CNT_W   = 4,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  // Count register: reset to the first phase duration, load or decrement
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller: NS/EW green, yellow and all-red
// clearance phases, pedestrian shortening of green, flashing-yellow mode.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int T_GREEN_NS = 9,
  parameter int T_GREEN_EW = 9,
  parameter int T_YELLOW   = 3,
  parameter int T_ALLRED   = 1,
  parameter int PED_MIN    = 3
) (
  input  logic             clk_light_cnt,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ped_req,
  input  logic             flash_req,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             ped_pending,
  output logic [2:0]       state
);

  localparam logic [CNT_W-1:0] D_GNS = CNT_W'(T_GREEN_NS);
  localparam logic [CNT_W-1:0] D_GEW = CNT_W'(T_GREEN_EW);
  localparam logic [CNT_W-1:0] D_YEL = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] D_AR  = CNT_W'(T_ALLRED);
  localparam logic [CNT_W-1:0] D_PED = CNT_W'(PED_MIN);

  function automatic logic [CNT_W-1:0] phase_dur(input state_e s);
    logic [CNT_W-1:0] d;
    case (s)
      NS_GREEN:             d = D_GNS;
      EW_GREEN:             d = D_GEW;
      NS_YELLOW, EW_YELLOW: d = D_YEL;
      ALLRED_A, ALLRED_B:   d = D_AR;
      default:              d = '0;
    endcase
    return d;
  endfunction

  state_e           r_state;
  logic             r_blink;
  logic             r_ped;
  logic [2:0]       r_ns_light;
  logic [2:0]       r_ew_light;

  state_e           w_next_state;
  logic             w_next_blink;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_dec;
  logic             w_ped_clr;
  logic             w_ped_set;
  logic [CNT_W-1:0] w_cnt;
  logic             w_last;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (D_GNS)
  ) u_timer (
    .i_clk      (clk_light_cnt),
    .i_rst_n    (rst_n),
    .i_en       (w_dec),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_cnt      (w_cnt),
    .o_last     (w_last)
  );

  // Next-phase decision; one action per enabled tick: flash > phase end > ped
  always_comb begin
    w_next_state = r_state;
    w_next_blink = r_blink;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_dec        = 1'b0;
    w_ped_clr    = 1'b0;
    if (en) begin
      if ((r_state != FLASH) && flash_req) begin
        w_next_state = FLASH;
        w_load       = 1'b1;
        w_load_val   = '0;
        w_next_blink = 1'b1;
        w_ped_clr    = 1'b1;
      end else if (r_state == FLASH) begin
        if (flash_req) begin
          w_next_blink = ~r_blink;
        end else begin
          w_next_state = ALLRED_B;
          w_load       = 1'b1;
          w_load_val   = D_AR;
          w_next_blink = 1'b0;
        end
      end else if (w_last) begin
        w_next_state = next_phase(r_state);
        w_load       = 1'b1;
        w_load_val   = phase_dur(w_next_state);
        w_ped_clr    = (w_next_state == NS_YELLOW) || (w_next_state == EW_YELLOW);
      end else if (((r_state == NS_GREEN) || (r_state == EW_GREEN)) &&
                   r_ped && (w_cnt > D_PED)) begin
        w_load     = 1'b1;
        w_load_val = D_PED;
        w_ped_clr  = 1'b1;
      end else begin
        w_dec = 1'b1;
      end
    end
    // Requests latch on every edge, enabled or not, except while flashing
    w_ped_set = ped_req && (r_state != FLASH);
  end

  // FSM state, blink, pedestrian latch and registered lamp outputs
  always_ff @(posedge clk_light_cnt or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= NS_GREEN;
      r_blink    <= 1'b0;
      r_ped      <= 1'b0;
      r_ns_light <= GRN;
      r_ew_light <= RED;
    end else begin
      r_state    <= w_next_state;
      r_blink    <= w_next_blink;
      r_ped      <= w_ped_set | (r_ped & ~w_ped_clr);
      r_ns_light <= ns_lamp(w_next_state, w_next_blink);
      r_ew_light <= ew_lamp(w_next_state, w_next_blink);
    end
  end

  assign ns_light    = r_ns_light;
  assign ew_light    = r_ew_light;
  assign phase_cnt   = w_cnt;
  assign ped_pending = r_ped;
  assign state       = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: directed scenarios followed by
// randomized stimulus, both compared against a phase-table reference model.
// Two instances run side by side: defaults, and CNT_W=5 / T_GREEN_NS=20.
module tb_traffic_light_ctrl;

  localparam int W       = 16;
  localparam int PED_MIN = 3;
  localparam int PH_FL   = 6;

  // ---------------- clock / reset ----------------
  logic clk       = 1'b0;
  logic rst_n     = 1'b1;
  logic en        = 1'b0;
  logic ped_req   = 1'b0;
  logic flash_req = 1'b0;

  always #5 clk = ~clk;

  logic [2:0] ns_a, ew_a, st_a;
  logic [3:0] cnt_a;
  logic       ped_a;
  logic [2:0] ns_b, ew_b, st_b;
  logic [4:0] cnt_b;
  logic       ped_b;

  traffic_light_ctrl dut_a (
    .clk_light_cnt (clk),
    .rst_n         (rst_n),
    .en            (en),
    .ped_req       (ped_req),
    .flash_req     (flash_req),
    .ns_light      (ns_a),
    .ew_light      (ew_a),
    .phase_cnt     (cnt_a),
    .ped_pending   (ped_a),
    .state         (st_a)
  );

  traffic_light_ctrl #(
    .CNT_W      (5),
    .T_GREEN_NS (20)
  ) dut_b (
    .clk_light_cnt (clk),
    .rst_n         (rst_n),
    .en            (en),
    .ped_req       (ped_req),
    .flash_req     (flash_req),
    .ns_light      (ns_b),
    .ew_light      (ew_b),
    .phase_cnt     (cnt_b),
    .ped_pending   (ped_b),
    .state         (st_b)
  );

  // ---------------- reference model ----------------
  // Phase index 0..5 follows the cycle order, 6 is flashing mode.
  typedef struct {
    int ph;
    int cnt;
    bit ped;
    bit blink;
  } mdl_t;

  int   dur_a[6] = '{9, 3, 1, 9, 3, 1};
  int   dur_b[6] = '{20, 3, 1, 9, 3, 1};
  mdl_t ma, mb;

  function automatic mdl_t mdl_reset(input int dur[6]);
    mdl_t m;
    m.ph = 0; m.cnt = dur[0]; m.ped = 1'b0; m.blink = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int dur[6],
                                    input bit e, input bit p, input bit f);
    mdl_t n = m;
    bit pset = p && (m.ph != PH_FL);
    bit pclr = 1'b0;
    if (e) begin
      if (f && m.ph != PH_FL) begin
        n.ph = PH_FL; n.cnt = 0; n.blink = 1'b1; pclr = 1'b1;
      end else if (m.ph == PH_FL) begin
        if (f) n.blink = !m.blink;
        else begin n.ph = 5; n.cnt = dur[5]; n.blink = 1'b0; end
      end else if (m.cnt == 1) begin
        n.ph  = (m.ph + 1) % 6;
        n.cnt = dur[n.ph];
        if (n.ph == 1 || n.ph == 4) pclr = 1'b1;
      end else if ((m.ph == 0 || m.ph == 3) && m.ped && m.cnt > PED_MIN) begin
        n.cnt = PED_MIN; pclr = 1'b1;
      end else begin
        n.cnt = m.cnt - 1;
      end
    end
    n.ped = pset || (m.ped && !pclr);
    return n;
  endfunction

  function automatic logic [2:0] ns_exp(input mdl_t m);
    if (m.ph == PH_FL) return m.blink ? 3'b010 : 3'b000;
    if (m.ph == 0) return 3'b001;
    if (m.ph == 1) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] ew_exp(input mdl_t m);
    if (m.ph == PH_FL) return m.blink ? 3'b010 : 3'b000;
    if (m.ph == 3) return 3'b001;
    if (m.ph == 4) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [W-1:0] pack(input mdl_t m);
    return {1'b0, 3'(m.ph), ns_exp(m), ew_exp(m), 5'(m.cnt), m.ped};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp();
    exp_q.push_back(pack(ma));
    exp_q.push_back(pack(mb));
  endtask

  task automatic compare_all();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check("a_state", {5'd0, st_a}, {5'd0, e[14:12]});
    check("a_ns",    {5'd0, ns_a}, {5'd0, e[11:9]});
    check("a_ew",    {5'd0, ew_a}, {5'd0, e[8:6]});
    check("a_cnt",   {4'd0, cnt_a}, {3'd0, e[5:1]});
    check("a_ped",   {7'd0, ped_a}, {7'd0, e[0]});
    e = exp_q.pop_front();
    check("b_state", {5'd0, st_b}, {5'd0, e[14:12]});
    check("b_ns",    {5'd0, ns_b}, {5'd0, e[11:9]});
    check("b_ew",    {5'd0, ew_b}, {5'd0, e[8:6]});
    check("b_cnt",   {3'd0, cnt_b}, {3'd0, e[5:1]});
    check("b_ped",   {7'd0, ped_b}, {7'd0, e[0]});
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge: drive inputs, advance model, check.
  task automatic step(input bit e, input bit p, input bit f);
    en = e; ped_req = p; flash_req = f;
    ma = mdl_step(ma, dur_a, e, p, f);
    mb = mdl_step(mb, dur_b, e, p, f);
    push_exp();
    @(posedge clk); #1;
    compare_all();
  endtask

  // Asynchronous reset between edges, checked before the next edge
  task automatic do_reset();
    en = 1'b0; ped_req = 1'b0; flash_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    ma = mdl_reset(dur_a);
    mb = mdl_reset(dur_b);
    push_exp();
    compare_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Run enabled ticks until model A reaches phase/count, within a budget
  task automatic advance_to(input int ph, input int cnt);
    int guard = 0;
    while (!(ma.ph == ph && ma.cnt == cnt) && guard < 60) begin
      step(1'b1, 1'b0, 1'b0);
      guard++;
    end
    check("advance_bound", {7'd0, guard < 60}, 8'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit f_lvl;
    do_reset();
    check("rst_state", {5'd0, st_a}, 8'd0);
    check("rst_cnt",   {4'd0, cnt_a}, 8'd9);
    check("rst_ns",    {5'd0, ns_a}, 8'h01);
    check("rst_ew",    {5'd0, ew_a}, 8'h04);

    // Full 26-tick cycle back to NS green
    for (int i = 0; i < 26; i++) step(1'b1, 1'b0, 1'b0);
    check("cycle_state", {5'd0, st_a}, 8'd0);
    check("cycle_cnt",   {4'd0, cnt_a}, 8'd9);

    // Pedestrian shortening of NS green at count 7
    advance_to(0, 7);
    step(1'b1, 1'b1, 1'b0);
    check("ped_latched", {7'd0, ped_a}, 8'd1);
    step(1'b1, 1'b0, 1'b0);
    check("ped_short_cnt", {4'd0, cnt_a}, 8'd3);
    check("ped_short_clr", {7'd0, ped_a}, 8'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check("ped_yellow", {5'd0, st_a}, 8'd1);

    // Late request in EW green: no shortening, cleared at yellow
    advance_to(3, 2);
    step(1'b1, 1'b1, 1'b0);
    check("ped_late_set", {7'd0, ped_a}, 8'd1);
    check("ped_late_cnt", {4'd0, cnt_a}, 8'd1);
    step(1'b1, 1'b0, 1'b0);
    check("ped_late_yel", {5'd0, st_a}, 8'd4);
    check("ped_late_clr", {7'd0, ped_a}, 8'd0);

    // Flash from EW yellow, blink, then exit via ALLRED_B
    step(1'b1, 1'b0, 1'b1);
    check("flash_state", {5'd0, st_a}, 8'd6);
    check("flash_on",    {5'd0, ns_a}, 8'h02);
    check("flash_cnt",   {4'd0, cnt_a}, 8'd0);
    step(1'b1, 1'b0, 1'b1);
    check("flash_off", {5'd0, ew_a}, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("flash_exit", {5'd0, st_a}, 8'd5);
    step(1'b1, 1'b0, 1'b0);
    check("flash_ns",     {5'd0, st_a}, 8'd0);
    check("flash_ns_cnt", {4'd0, cnt_a}, 8'd9);

    // Enable low freezes the count at 4
    advance_to(0, 4);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    check("freeze_cnt", {4'd0, cnt_a}, 8'd4);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check("resume_cnt", {4'd0, cnt_a}, 8'd1);

    // Async reset mid-EW green and mid-flash
    advance_to(3, 5);
    do_reset();
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    do_reset();
    check("rst_flash_ped", {7'd0, ped_a}, 8'd0);

    // Wide instance counts 20..1 without wrap
    check("wide_start", {3'd0, cnt_b}, 8'd20);
    for (int i = 0; i < 19; i++) step(1'b1, 1'b0, 1'b0);
    check("wide_last", {3'd0, cnt_b}, 8'd1);
    step(1'b1, 1'b0, 1'b0);
    check("wide_yellow", {5'd0, st_b}, 8'd1);

    // Randomized traffic
    f_lvl = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        f_lvl = 1'b0;
      end
      if ($urandom_range(0, 29) == 0) f_lvl = !f_lvl;
      step($urandom_range(0, 9) != 0,
           !f_lvl && ($urandom_range(0, 11) == 0),
           f_lvl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
